sin_nco_pa: RTL and testbench

SIN_NCO_PA -- requirements
Module: sin_nco_pa

---
 rtl/nco_pkg.sv | 37 +++
 rtl/nco_quarter_rom.sv | 38 +++
 rtl/sin_nco_pa.sv | 159 +++++++++++++++
 tb/tb_sin_nco_pa.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants for the sine NCO: default widths, quadrant encoding
// and the quarter-wave table amplitude.
package nco_pkg;

    localparam int NCO_PHASE_W  = 24;
    localparam int NCO_SAMPLE_W = 16;
    localparam int NCO_LUT_BITS = 8;
    localparam int NCO_DIV_W    = 16;

    localparam real NCO_PI = 3.14159265358979323846;

    // Quadrant = top two bits of the sample phase.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Peak table value; symmetric so the negated value always fits.
    function automatic int nco_amp(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

    localparam int NCO_AMP = nco_amp(NCO_SAMPLE_W);

    // Odd quadrants walk the quarter table backwards.
    function automatic logic quad_mirror(input quad_e q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    // Lower half of the circle is the negated upper half.
    function automatic logic quad_negate(input quad_e q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine table with a registered, read-enabled output.
// Ports: clk_i, rd_en_i, addr_i[LUT_BITS] -> data_o[SAMPLE_W] (one clock later).
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int LUT_BITS = NCO_LUT_BITS,
    parameter int SAMPLE_W = NCO_SAMPLE_W
) (
    input  logic                clk_i,
    input  logic                rd_en_i,
    input  logic [LUT_BITS-1:0] addr_i,
    output logic [SAMPLE_W-1:0] data_o
);

    localparam int DEPTH = 1 << LUT_BITS;

    logic [SAMPLE_W-1:0] rom [DEPTH];
    logic [SAMPLE_W-1:0] data_q;

    // Entries are sampled at bin centres (k+0.5) so the table never
    // contains 0 and quadrant mirroring needs no special cases.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANG = 2.0 * NCO_PI * (real'(k) + 0.5)
                              / real'(4 * DEPTH);
        localparam int VAL = $rtoi(real'(nco_amp(SAMPLE_W)) * $sin(ANG)
                                   + 0.5);
        assign rom[k] = SAMPLE_W'(VAL);
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sin_nco_pa.sv
// Divided-rate sine NCO: phase accumulator, quarter-wave lookup, 3-stage pipe.
// Ports: clk, rst_n, en, nco_div, tune_word, phase_off -> nco_out, out_valid,
// ncoovfsync (first sample after an accumulator wrap).
module sin_nco_pa
    import nco_pkg::*;
#(
    parameter int PHASE_W  = NCO_PHASE_W,
    parameter int SAMPLE_W = NCO_SAMPLE_W,
    parameter int LUT_BITS = NCO_LUT_BITS,
    parameter int DIV_W    = NCO_DIV_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DIV_W-1:0]    nco_div,
    input  logic [PHASE_W-1:0]  tune_word,
    input  logic [PHASE_W-1:0]  phase_off,
    output logic [SAMPLE_W-1:0] nco_out,
    output logic                out_valid,
    output logic                ncoovfsync
);

    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PHASE_W-1:0]  acc_q, acc_d;
    logic [PHASE_W-1:0]  tune_q, tune_d;
    logic                wrap_q, wrap_d;

    logic                tick;
    logic [PHASE_W:0]    sum;
    logic [PHASE_W-1:0]  phase;
    quad_e               quad_d;
    logic [LUT_BITS-1:0] idx_raw, idx_d;
    logic                unused_phase;

    logic                v1_q, ovf1_q;
    quad_e               quad1_q;
    logic [LUT_BITS-1:0] idx_q;

    logic                v2_q, ovf2_q;
    quad_e               quad2_q;
    logic [SAMPLE_W-1:0] rom_data;

    logic [SAMPLE_W-1:0] out_q, out_d;
    logic                valid_q, sync_q;

    // Tick compares against the divider captured at the previous tick,
    // so a new nco_div only shapes the period after the next tick.
    always_comb begin
        tick   = en && (cnt_q == div_q);
        phase  = acc_q + phase_off;
        sum    = {1'b0, acc_q} + {1'b0, tune_q};
        cnt_d  = cnt_q;
        div_d  = div_q;
        acc_d  = acc_q;
        tune_d = tune_q;
        wrap_d = wrap_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            acc_d  = sum[PHASE_W-1:0];
            wrap_d = sum[PHASE_W];
            div_d  = nco_div;
            tune_d = tune_word;
        end
    end

    always_comb begin
        quad_d  = quad_e'(phase[PHASE_W-1 -: 2]);
        idx_raw = phase[PHASE_W-3 -: LUT_BITS];
        idx_d   = quad_mirror(quad_d) ? ~idx_raw : idx_raw;
    end

    assign unused_phase = ^phase[PHASE_W-3-LUT_BITS:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= '0;
            acc_q  <= '0;
            tune_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            acc_q  <= acc_d;
            tune_q <= tune_d;
            wrap_q <= wrap_d;
        end
    end

    // Stage 1: quadrant and table address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            ovf1_q  <= 1'b0;
            quad1_q <= QUAD_0;
            idx_q   <= '0;
        end else begin
            v1_q <= tick;
            if (tick) begin
                ovf1_q  <= wrap_q;
                quad1_q <= quad_d;
                idx_q   <= idx_d;
            end
        end
    end

    // Stage 2: table read; side-band travels alongside.
    nco_quarter_rom #(
        .LUT_BITS (LUT_BITS),
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .clk_i   (clk),
        .rd_en_i (v1_q),
        .addr_i  (idx_q),
        .data_o  (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            ovf2_q  <= 1'b0;
            quad2_q <= QUAD_0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                ovf2_q  <= ovf1_q;
                quad2_q <= quad1_q;
            end
        end
    end

    // Stage 3: sign and output register; holds between samples.
    always_comb begin
        out_d = out_q;
        if (v2_q) begin
            out_d = quad_negate(quad2_q) ? -rom_data : rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= v2_q;
            sync_q  <= v2_q & ovf2_q;
        end
    end

    assign nco_out    = out_q;
    assign out_valid  = valid_q;
    assign ncoovfsync = sync_q;

endmodule

// File: tb/tb_sin_nco_pa.sv
// Scoreboard bench for sin_nco_pa: a spec-level model pushes expected
// samples at each tick; a monitor pops and compares them on out_valid.
module tb_sin_nco_pa;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] nco_div;
    logic [23:0] tune_word;
    logic [23:0] phase_off;
    logic [15:0] nco_out;
    logic        out_valid;
    logic        ncoovfsync;

    sin_nco_pa #(
        .PHASE_W  (24),
        .SAMPLE_W (16),
        .LUT_BITS (8),
        .DIV_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .nco_div    (nco_div),
        .tune_word  (tune_word),
        .phase_off  (phase_off),
        .nco_out    (nco_out),
        .out_valid  (out_valid),
        .ncoovfsync (ncoovfsync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int s;
        bit ovf;
        int t;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Full-circle sine at the centre of the 1024-bin the phase falls in.
    function automatic int ref_sample(input logic [23:0] ph);
        real a;
        real v;
        int  n;
        n = int'(ph >> 14);
        a = 2.0 * PI * (real'(n) + 0.5) / 1024.0;
        v = 32767.0 * $sin(a);
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(-v + 0.5));
    endfunction

    // Reference model: divider, capture-on-tick, accumulator, wrap flag.
    logic [15:0] m_cnt, m_cap;
    logic [23:0] m_acc, m_tune;
    logic [24:0] m_sum;
    bit          m_wrap;
    exp_t        m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt  = '0;
            m_cap  = '0;
            m_acc  = '0;
            m_tune = '0;
            m_wrap = 1'b0;
            sb.delete();
        end else begin
            if (en) begin
                if (m_cnt == m_cap) begin
                    m_e.s   = ref_sample(m_acc + phase_off);
                    m_e.ovf = m_wrap;
                    m_e.t   = cyc;
                    sb.push_back(m_e);
                    m_sum  = {1'b0, m_acc} + {1'b0, m_tune};
                    m_wrap = m_sum[24];
                    m_acc  = m_sum[23:0];
                    m_cap  = nco_div;
                    m_tune = tune_word;
                    m_cnt  = '0;
                end else begin
                    m_cnt = m_cnt + 16'd1;
                end
            end
            cyc++;
        end
    end

    // Monitor: every strobe must match the head of the scoreboard;
    // between strobes the output must hold and the sync must stay low.
    logic [15:0] last_out;
    exp_t        mon_e;

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            last_out = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sample", $signed(nco_out), mon_e.s);
                chk("ovfsync", ncoovfsync, mon_e.ovf);
                chk("latency", cyc - mon_e.t, 3);
            end
            last_out = nco_out;
        end else begin
            chk("hold", nco_out, last_out);
            chk("sync_qual", ncoovfsync, 0);
        end
    end

    task automatic wait_valid(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("timeout", 0, 1);
    endtask

    int c0, c1, c2, c3;
    int pulses;
    int qs [5] = '{101, 32767, -101, -32767, 101};
    bit qo [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        nco_div   = 16'd0;
        tune_word = 24'h40_0000;
        phase_off = 24'h00_0000;

        repeat (3) begin
            @(negedge clk);
            chk("rst_out", nco_out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_sync", ncoovfsync, 0);
        end
        rst_n = 1'b1;

        wait_valid(10, c0);
        chk("first_tick", $signed(nco_out), 101);
        for (int i = 0; i < 5; i++) begin
            wait_valid(4, c1);
            chk("quarter_val", $signed(nco_out), qs[i]);
            chk("quarter_sync", ncoovfsync, qo[i]);
        end
        repeat (20) @(negedge clk);

        en = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("gate_pulses", pulses <= 3, 1);
        en = 1'b1;
        repeat (12) @(negedge clk);

        nco_div = 16'd3;
        repeat (20) @(negedge clk);
        wait_valid(10, c0);
        nco_div = 16'd7;
        wait_valid(10, c1);
        wait_valid(12, c2);
        wait_valid(12, c3);
        chk("div_cur", c1 - c0, 4);
        chk("div_new", c2 - c1, 8);
        chk("div_new2", c3 - c2, 8);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", nco_out, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_sync", ncoovfsync, 0);
        #1 rst_n = 1'b1;
        wait_valid(10, c0);
        chk("arst_restart", $signed(nco_out), 101);
        repeat (30) @(negedge clk);

        @(negedge clk);
        nco_div   = 16'd0;
        tune_word = 24'h00_0000;
        phase_off = 24'h80_0000;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(6, c1);
            chk("offset_val", $signed(nco_out), -101);
            chk("offset_sync", ncoovfsync, 0);
        end
        repeat (10) @(negedge clk);

        en = 1'b0;
        repeat (6) @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
